// File: rtl/td4_prog_store.sv
// td4_prog_store: TD4 instruction store. It holds a 16 x 8-bit program that is
// byte-loaded over a valid/ready port. In RUN it presents mem[pc] to the CPU as
// {immediate, opcode}.
// Optional build macro TD4_PROG_DEFAULT_EN: reset preloads a LED-chaser program
// instead of all-zero words.
module td4_prog_store #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_mode,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic [3:0]       wr_addr,
   output logic             prog_full,
   input  logic [3:0]       pc,
   output logic [3:0]       opcode,
   output logic [3:0]       immediate,
   output logic             cpu_run
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [3:0]       addr_reg;
   logic             full_reg;
   logic             write_en;
   logic             enter_load;
   logic [WIDTH-1:0] fetch_word;
   logic [WIDTH-1:0] mem_reg [DEPTH];

   // Value a word takes on reset: a chaser program or all zeros.
   function automatic logic [WIDTH-1:0] boot_word(input int idx);
      logic [WIDTH-1:0] w;
      w = '0;
`ifdef TD4_PROG_DEFAULT_EN
      case (idx)
         0:       w = WIDTH'(8'h1B);   // OUT 1
         1:       w = WIDTH'(8'h2B);   // OUT 2
         2:       w = WIDTH'(8'h4B);   // OUT 4
         3:       w = WIDTH'(8'h8B);   // OUT 8
         4:       w = WIDTH'(8'h0F);   // JMP 0
         default: w = '0;
      endcase
`else
      if (idx < 0) w = '0;
`endif
      return w;
   endfunction

   // Writes are accepted only while the loader owns the memory. A write in the
   // last LOAD cycle, when load_mode has already dropped, still lands.
   assign write_en   = wr_valid && (state_reg == LOAD);
   // Any edge into LOAD restarts the load at address 0.
   assign enter_load = load_mode && (state_reg != LOAD);

   // Next state depends only on load_mode. IDLE and RUN both move to LOAD when
   // load_mode is 1, and every state moves to RUN when load_mode is 0.
   always_comb begin
      state_next = RUN;
      if (load_mode) state_next = LOAD;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Load pointer and full flag. A write never coincides with LOAD entry,
   // because entry happens from a state that ignores writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_reg <= 4'd0;
         full_reg <= 1'b0;
      end else if (enter_load) begin
         addr_reg <= 4'd0;
         full_reg <= 1'b0;
      end else if (write_en) begin
         addr_reg <= addr_reg + 4'd1;
         if (addr_reg == 4'd15) full_reg <= 1'b1;
      end
   end

   // Program words. Each word is a register with its own reset value, so a
   // reset clears or preloads the whole program in one cycle.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         localparam logic [WIDTH-1:0] BOOT = boot_word(gi);
         // Capture the loader byte when this word is the write target.
         always_ff @(posedge clk) begin
            if (!rst_n)
               mem_reg[gi] <= BOOT;
            else if (write_en && (addr_reg == 4'(gi)))
               mem_reg[gi] <= wr_data;
         end
      end
   endgenerate

   // Zero-latency fetch. Outside RUN the CPU sees 8'h00 (ADD A,0), which has
   // no side effects.
   always_comb begin
      fetch_word = '0;
      if (state_reg == RUN) fetch_word = mem_reg[pc];
   end

   assign opcode    = fetch_word[3:0];
   assign immediate = fetch_word[7:4];
   assign wr_ready  = (state_reg == LOAD);
   assign cpu_run   = (state_reg == RUN);
   assign wr_addr   = addr_reg;
   assign prog_full = full_reg;

endmodule

// File: tb/tb_td4_prog_store.sv
// Testbench for td4_prog_store. Directed stimulus drives the DUT. A reference
// model of the program store is compared against the DUT every cycle, and
// hand-computed literal expectations are checked at key points.
module tb_td4_prog_store;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_mode;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [3:0] wr_addr;
   logic       prog_full;
   logic [3:0] pc;
   logic [3:0] opcode;
   logic [3:0] immediate;
   logic       cpu_run;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   td4_prog_store dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_mode (load_mode),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .prog_full (prog_full),
      .pc        (pc),
      .opcode    (opcode),
      .immediate (immediate),
      .cpu_run   (cpu_run)
   );

   always #5 clk = ~clk;

   // Reference model: program array, load pointer, full flag, and two mode flags.
   logic [7:0] m_mem [16];
   int         m_ptr;
   bit         m_full;
   bit         m_loading;
   bit         m_running;

   function automatic logic [7:0] m_boot(input int i);
      logic [7:0] tbl [5];
      tbl = '{8'h1B, 8'h2B, 8'h4B, 8'h8B, 8'h0F};
`ifdef TD4_PROG_DEFAULT_EN
      if (i < 5) return tbl[i];
`else
      if (i < 0) return tbl[0];
`endif
      return 8'h00;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_mem[i] = m_boot(i);
         m_ptr = 0; m_full = 1'b0; m_loading = 1'b0; m_running = 1'b0;
      end else begin
         if (m_loading && wr_valid) begin
            m_mem[m_ptr] = wr_data;
            if (m_ptr == 15) m_full = 1'b1;
            m_ptr = (m_ptr + 1) % 16;
         end
         if (load_mode) begin
            if (!m_loading) begin m_ptr = 0; m_full = 1'b0; end
            m_loading = 1'b1; m_running = 1'b0;
         end else begin
            m_loading = 1'b0; m_running = 1'b1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc wr_ready",  int'(wr_ready),  int'(m_loading));
         check("cyc cpu_run",   int'(cpu_run),   int'(m_running));
         check("cyc wr_addr",   int'(wr_addr),   m_ptr);
         check("cyc prog_full", int'(prog_full), int'(m_full));
         check("cyc opcode",    int'(opcode),    m_running ? int'(m_mem[pc][3:0]) : 0);
         check("cyc immediate", int'(immediate), m_running ? int'(m_mem[pc][7:4]) : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int p, input int exp_op, input int exp_imm);
      pc = 4'(p);
      #1;
      check("fetch opcode", int'(opcode), exp_op);
      check("fetch imm",    int'(immediate), exp_imm);
      $display("fetch pc=%0d op=%0h imm=%0h", p, opcode, immediate);
   endtask

   initial begin
      rst_n = 1'b0; load_mode = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; pc = 4'd5;

      // 1: reset, then RUN
      step();
      chk_en = 1'b1;
      check("rst wr_ready", int'(wr_ready), 0);
      check("rst opcode",   int'(opcode), 0);
      check("rst cpu_run",  int'(cpu_run), 0);
      rst_n = 1'b1;
      step();
      check("run cpu_run", int'(cpu_run), 1);
`ifndef TD4_PROG_DEFAULT_EN
      fetch(5, 0, 0);
`endif

      // 2: three writes; the last is sent while load_mode already drops
      load_mode = 1'b1;
      step();
      check("load wr_ready", int'(wr_ready), 1);
      check("load wr_addr",  int'(wr_addr), 0);
      wr_valid = 1'b1; wr_data = 8'h31; step();
      $display("write 31 wr_addr=%0d", wr_addr);
      wr_data = 8'h52; step();
      $display("write 52 wr_addr=%0d", wr_addr);
      wr_data = 8'hF3; load_mode = 1'b0; step();
      $display("write F3 (last LOAD cycle) wr_addr=%0d", wr_addr);
      wr_valid = 1'b0;
      fetch(0, 1, 3);
      fetch(1, 2, 5);
      fetch(2, 3, 15);

      // 3: seventeen writes, wrapping to address 0
      load_mode = 1'b1;
      step();
      check("reentry wr_addr", int'(wr_addr), 0);
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1; wr_data = 8'(i);
         step();
         $display("write %0h wr_addr=%0d prog_full=%0d", i, wr_addr, prog_full);
         if (i == 14) check("full before 16th", int'(prog_full), 0);
         if (i == 15) check("full after 16th",  int'(prog_full), 1);
      end
      check("wrap wr_addr", int'(wr_addr), 1);
      check("full held",    int'(prog_full), 1);
      wr_valid = 1'b0; load_mode = 1'b0;
      step();

      // 4: writes in RUN are ignored
      wr_valid = 1'b1; wr_data = 8'hFF;
      #1;
      check("run wr_ready", int'(wr_ready), 0);
      step();
      wr_valid = 1'b0;
      for (int p = 0; p < 16; p++)
         fetch(p, (p == 0) ? 0 : p, (p == 0) ? 1 : 0);

      // 5: reset in the middle of a load
      load_mode = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = 8'hA0 + 8'(i); step();
      end
      wr_valid = 1'b0; rst_n = 1'b0;
      step();
      check("abort wr_addr",   int'(wr_addr), 0);
      check("abort prog_full", int'(prog_full), 0);
      check("abort wr_ready",  int'(wr_ready), 0);
      check("abort cpu_run",   int'(cpu_run), 0);
      rst_n = 1'b1; load_mode = 1'b0;
      step();
`ifdef TD4_PROG_DEFAULT_EN
      // 6: the built-in chaser program after reset
      fetch(3, 11, 8);
      fetch(4, 15, 0);
      fetch(9, 0, 0);
`else
      for (int p = 0; p < 16; p++) fetch(p, 0, 0);
`endif
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
